// File: rtl/adder2_arbiter.sv
// Round-robin arbiter sharing one 64+64->65 adder between N_REQ requesters.
// One operation in flight at a time: IDLE (grant) -> CALC (add) -> RESULT (hold until consumed).

module adder2 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [64:0] sout
);
    assign sout = {1'b0, a} + {1'b0, b};
endmodule

module adder2_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [64*N_REQ-1:0] req_a,
    input  logic [64*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                res_valid,
    output logic [64:0]         res_sum,
    output logic [ID_W-1:0]     res_id,
    input  logic                res_ready,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] cur_id_q, cur_id_d;
    logic [63:0]     op_a_q, op_a_d;
    logic [63:0]     op_b_q, op_b_d;
    logic            res_valid_q, res_valid_d;
    logic [64:0]     res_sum_q, res_sum_d;
    logic [ID_W-1:0] res_id_q, res_id_d;

    logic [63:0]     a_arr [N_REQ];
    logic [63:0]     b_arr [N_REQ];
    logic [ID_W:0]   cand;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic            grant_en;
    logic [64:0]     sout;
    logic            handshake;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_arr[gi] = req_a[64*gi +: 64];
            assign b_arr[gi] = req_b[64*gi +: 64];
        end
    endgenerate

    // Rotating search starting at ptr; candidate index is kept below N_REQ so
    // non-power-of-2 configurations never look at a nonexistent requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    adder2 u_adder2 (
        .a    (op_a_q),
        .b    (op_b_q),
        .sout (sout)
    );

    assign handshake = res_valid_q && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_en) state_d = S_CALC;
            S_CALC:   state_d = S_RESULT;
            S_RESULT: if (handshake) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Grant is suppressed while rst is high so nothing is acknowledged in the reset cycle.
    always_comb begin
        grant_en = (state_q == S_IDLE) && grant_found && !rst;
        busy     = (state_q != S_IDLE);
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d       = ptr_q;
        cur_id_d    = cur_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    op_a_d   = a_arr[grant_id];
                    op_b_d   = b_arr[grant_id];
                    cur_id_d = grant_id;
                end
            end
            S_CALC: begin
                res_sum_d   = sout;
                res_id_d    = cur_id_q;
                res_valid_d = 1'b1;
            end
            S_RESULT: begin
                if (handshake) begin
                    res_valid_d = 1'b0;
                    ptr_d       = (cur_id_q == ID_W'(N_REQ-1)) ? '0 : cur_id_q + 1'b1;
                end
            end
            default: begin
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cur_id_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cur_id_q    <= cur_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder2_arbiter.sv
// Directed bench for adder2_arbiter: reset, arithmetic, fairness, backpressure,
// pointer wrap and mid-operation reset. Inputs change on falling edges.

module tb_adder2_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic [64:0]  res_sum;
    logic [1:0]   res_id;
    logic         res_ready;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    adder2_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_op(input int id, input logic [63:0] a, input logic [63:0] b);
        req_a[64*id +: 64] = a;
        req_b[64*id +: 64] = b;
        req_valid[id]      = 1'b1;
    endtask

    // Called at a falling edge in IDLE with the request already presented.
    task automatic expect_op(input int id, input logic [64:0] exp_sum, input string name);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << id;
        #1;
        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, exp_rdy);
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        n_vec++;
        if (res_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0) begin
            n_err++;
            $display("FAIL %s calc: res_valid=%b busy=%b req_ready=%b expected 0 1 0000",
                     name, res_valid, busy, req_ready);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (res_valid !== 1'b1 || res_sum !== exp_sum || res_id !== 2'(id)) begin
            n_err++;
            $display("FAIL %s result: valid=%b sum=%0d id=%0d expected 1 %0d %0d",
                     name, res_valid, res_sum, res_id, exp_sum, id);
        end
        $display("op %s: id=%0d sum=%0d", name, res_id, res_sum);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done: res_valid=%b busy=%b expected 0 0", name, res_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_vec++;
            if ({req_ready, res_valid, res_sum, res_id, busy} !== '0) begin
                n_err++;
                $display("FAIL reset_idle c%0d: ready=%b valid=%b sum=%0d id=%0d busy=%b expected all 0",
                         c, req_ready, res_valid, res_sum, res_id, busy);
            end
            @(negedge clk);
        end
        $display("reset: 10 quiet idle cycles observed");
    endtask

    task automatic test_arith();
        set_op(1, 64'd184, 64'd1256);
        expect_op(1, 65'd1440, "arith0");
        set_op(1, 64'd156596564, 64'd125556);
        expect_op(1, 65'd156722120, "arith1");
        set_op(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        expect_op(1, 65'h0_FFFF_FFFF_FFFF_FFFF, "arith2");
        set_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        expect_op(1, 65'h1_0000_0000_0000_0000, "arith3");
    endtask

    task automatic test_fairness();
        int k;
        int eid;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 64'(i), 64'd7);
        res_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            #1;
            k   = c / 3;
            eid = k % 4;
            n_vec++;
            case (c % 3)
                0: if (req_ready !== (4'b0001 << eid)) begin
                       n_err++;
                       $display("FAIL fair_grant c%0d: req_ready=%b expected %b", c, req_ready, 4'b0001 << eid);
                   end
                1: if (req_ready !== 4'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
                       n_err++;
                       $display("FAIL fair_calc c%0d: ready=%b busy=%b valid=%b expected 0000 1 0",
                                c, req_ready, busy, res_valid);
                   end
                default: begin
                    if (res_valid !== 1'b1 || res_sum !== 65'(eid + 7) || res_id !== 2'(eid)) begin
                        n_err++;
                        $display("FAIL fair_result c%0d: valid=%b sum=%0d id=%0d expected 1 %0d %0d",
                                 c, res_valid, res_sum, res_id, eid + 7, eid);
                    end
                    $display("op fair%0d: id=%0d sum=%0d", k, res_id, res_sum);
                end
            endcase
            @(negedge clk);
        end
        req_valid = '0;
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req_valid = '0;
        set_op(0, 64'd100, 64'd23);
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_grant0: req_ready=%b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        set_op(2, 64'd5, 64'd6);
        #1;
        n_vec++;
        if (req_ready !== 4'b0) begin
            n_err++;
            $display("FAIL bp_calc: req_ready=%b expected 0000", req_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (res_valid !== 1'b1 || res_sum !== 65'd123 || res_id !== 2'd0 || req_ready !== 4'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b sum=%0d id=%0d ready=%b expected 1 123 0 0000",
                         i, res_valid, res_sum, res_id, req_ready);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0) begin
            n_err++;
            $display("FAIL bp_hs: req_ready=%b expected 0000", req_ready);
        end
        $display("op bp0: id=%0d sum=%0d", res_id, res_sum);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 4'b0100 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_grant2: ready=%b valid=%b expected 0100 0", req_ready, res_valid);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if (res_valid !== 1'b1 || res_sum !== 65'd11 || res_id !== 2'd2) begin
            n_err++;
            $display("FAIL bp_result2: valid=%b sum=%0d id=%0d expected 1 11 2", res_valid, res_sum, res_id);
        end
        $display("op bp2: id=%0d sum=%0d", res_id, res_sum);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_wrap();
        set_op(3, 64'd1, 64'd2);
        expect_op(3, 65'd3, "wrap3");
        set_op(0, 64'd10, 64'd20);
        set_op(3, 64'd30, 64'd40);
        expect_op(0, 65'd30, "wrap0_first");
        expect_op(3, 65'd70, "wrap3_second");
    endtask

    task automatic test_reset_mid();
        // Run in CALC: leave ptr at 3, then abort an op from requester 3.
        set_op(2, 64'd9, 64'd9);
        expect_op(2, 65'd18, "pre_rst");
        set_op(3, 64'd7, 64'd7);
        #1;
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL rstc_grant: req_ready=%b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        set_op(1, 64'd1000, 64'd1);
        set_op(3, 64'd7, 64'd7);
        #1;
        n_vec++;
        if (req_ready !== 4'b0 || res_valid !== 1'b0 || busy !== 1'b0 || res_sum !== 65'd0) begin
            n_err++;
            $display("FAIL rstc_state: ready=%b valid=%b busy=%b sum=%0d expected 0000 0 0 0",
                     req_ready, res_valid, busy, res_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        expect_op(1, 65'd1001, "rstc_next");
        // Run in RESULT: ptr now 2, requester 3 still pending.
        #1;
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL rstr_grant: req_ready=%b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if (res_valid !== 1'b1 || res_sum !== 65'd14 || res_id !== 2'd3) begin
            n_err++;
            $display("FAIL rstr_pending: valid=%b sum=%0d id=%0d expected 1 14 3", res_valid, res_sum, res_id);
        end
        rst = 1'b1;
        @(negedge clk);
        set_op(1, 64'd1000, 64'd1);
        set_op(2, 64'd50, 64'd50);
        #1;
        n_vec++;
        if (req_ready !== 4'b0 || res_valid !== 1'b0 || busy !== 1'b0 || res_id !== 2'd0) begin
            n_err++;
            $display("FAIL rstr_state: ready=%b valid=%b busy=%b id=%0d expected 0000 0 0 0",
                     req_ready, res_valid, busy, res_id);
        end
        @(negedge clk);
        rst = 1'b0;
        expect_op(1, 65'd1001, "rstr_next");
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
